// File: rtl/cache_refill_pkg.sv
// Shared types and width helpers for the cache refill memory responder.
package cache_refill_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      BURST = 2'd2
   } state_e;

   localparam int WORD_BYTES = 4;
   localparam int BYTE_OFF_W = $clog2(WORD_BYTES);

   function automatic int off_width(input int words_per_line);
      return (words_per_line > 1) ? $clog2(words_per_line) : 0;
   endfunction

   function automatic int idx_width(input int addr_w);
      return addr_w - BYTE_OFF_W;
   endfunction

endpackage

// File: rtl/cache_refill_mem_if.sv
// Refill request/response bundle between the cache miss path and the memory.
// Write-port signals exist only when CACHE_REFILL_MEM_WRITE_EN is defined.
interface cache_refill_mem_if #(parameter int ADDR_W = 32);

   logic              req_valid;
   logic              req_ready;
   logic [ADDR_W-1:0] req_addr;
   logic              resp_valid;
   logic              resp_ready;
   logic [31:0]       resp_data;
   logic              resp_last;
   logic              resp_err;
`ifdef CACHE_REFILL_MEM_WRITE_EN
   logic              wr_valid;
   logic              wr_ready;
   logic [ADDR_W-1:0] wr_addr;
   logic [31:0]       wr_data;
`endif

   modport master (
      output req_valid, req_addr, resp_ready,
      input  req_ready, resp_valid, resp_data, resp_last, resp_err
`ifdef CACHE_REFILL_MEM_WRITE_EN
      , output wr_valid, wr_addr, wr_data
      , input  wr_ready
`endif
   );

   modport slave (
      input  req_valid, req_addr, resp_ready,
      output req_ready, resp_valid, resp_data, resp_last, resp_err
`ifdef CACHE_REFILL_MEM_WRITE_EN
      , input  wr_valid, wr_addr, wr_data
      , output wr_ready
`endif
   );

endinterface

// File: rtl/cache_refill_mem_array.sv
// Synchronous-read word store; word i powers up holding i. Optional write port
// under CACHE_REFILL_MEM_WRITE_EN. rd_clr loads zero instead of the addressed word.
module cache_refill_mem_array #(
   parameter int MEM_WORDS = 1024,
   parameter int MEM_AW    = $clog2(MEM_WORDS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rd_en,
   input  logic              rd_clr,
   input  logic [MEM_AW-1:0] rd_addr,
   output logic [31:0]       rd_data
`ifdef CACHE_REFILL_MEM_WRITE_EN
   ,
   input  logic              wr_en,
   input  logic [MEM_AW-1:0] wr_addr,
   input  logic [31:0]       wr_data
`endif
);

   typedef logic [31:0] mem_t [MEM_WORDS];

   function automatic mem_t init_pattern();
      mem_t m;
      for (int i = 0; i < MEM_WORDS; i++) begin
         m[i] = 32'(i);
      end
      return m;
   endfunction

   mem_t mem_r = init_pattern();

   // Read register; only the output register sees reset, storage never does.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_data <= 32'h0;
      end else if (rd_en) begin
         rd_data <= rd_clr ? 32'h0 : mem_r[rd_addr];
      end
   end

`ifdef CACHE_REFILL_MEM_WRITE_EN
   // Word write port.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_r[wr_addr] <= wr_data;
      end
   end
`endif

endmodule

// File: rtl/cache_refill_mem.sv
// Backing memory for cache line refills: fixed latency, then a line-aligned burst.
// Optional write port enabled by CACHE_REFILL_MEM_WRITE_EN.
module cache_refill_mem
   import cache_refill_pkg::*;
#(
   parameter int ADDR_W         = 32,
   parameter int MEM_WORDS      = 1024,
   parameter int WORDS_PER_LINE = 4,
   parameter int LATENCY        = 3
) (
   input logic               clk,
   input logic               rst_n,
   cache_refill_mem_if.slave bus
);

   localparam int IDX_W  = idx_width(ADDR_W);
   localparam int OFF_W  = off_width(WORDS_PER_LINE);
   localparam int MEM_AW = $clog2(MEM_WORDS);
   localparam int CNT_W  = $clog2(LATENCY + 2);
   localparam int BEAT_W = OFF_W + 1;

   state_e              state_r;
   logic [IDX_W-1:0]    base_r;
   logic                err_r;
   logic [CNT_W-1:0]    cnt_r;
   logic [BEAT_W-1:0]   beat_r;
   logic                req_ready_r;
   logic                resp_valid_r;
   logic                resp_last_r;
   logic                resp_err_r;

   logic [IDX_W-1:0]    idx_s;
   logic [IDX_W-1:0]    base_s;
   logic                range_err_s;
   logic                wr_block_s;
   logic                accept_s;
   logic                last_take_s;
   logic                load_s;
   logic [MEM_AW-1:0]   rd_addr_s;
   logic [31:0]         rd_data_s;
`ifdef CACHE_REFILL_MEM_WRITE_EN
   logic                wr_ready_s;
   logic [IDX_W-1:0]    wr_idx_s;
   logic                wr_en_s;
`endif

   // Request decode, handshake qualifiers and read address for the next beat.
   always_comb begin
      idx_s       = IDX_W'(bus.req_addr >> BYTE_OFF_W);
      base_s      = idx_s & ~IDX_W'(WORDS_PER_LINE - 1);
      // One extra bit so a line near the top of the index space cannot wrap back in range.
      range_err_s = ({1'b0, base_s} + (IDX_W + 1)'(WORDS_PER_LINE)) > (IDX_W + 1)'(MEM_WORDS);
`ifdef CACHE_REFILL_MEM_WRITE_EN
      wr_ready_s  = req_ready_r && rst_n;
      wr_block_s  = bus.wr_valid && wr_ready_s;
      wr_idx_s    = IDX_W'(bus.wr_addr >> BYTE_OFF_W);
      wr_en_s     = wr_block_s && ({1'b0, wr_idx_s} < (IDX_W + 1)'(MEM_WORDS));
`else
      wr_block_s  = 1'b0;
`endif
      accept_s    = bus.req_valid && req_ready_r && !wr_block_s;
      last_take_s = resp_valid_r && bus.resp_ready && resp_last_r;
      load_s      = (state_r == BURST) && !last_take_s && (!resp_valid_r || bus.resp_ready);
      rd_addr_s   = MEM_AW'(base_r | IDX_W'(beat_r));
   end

   // Refill sequencer: IDLE -> WAIT (LATENCY cycles) -> BURST.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r      <= IDLE;
         base_r       <= '0;
         err_r        <= 1'b0;
         cnt_r        <= '0;
         beat_r       <= '0;
         req_ready_r  <= 1'b0;
         resp_valid_r <= 1'b0;
         resp_last_r  <= 1'b0;
         resp_err_r   <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               req_ready_r <= 1'b1;
               if (accept_s) begin
                  base_r      <= base_s;
                  err_r       <= range_err_s;
                  cnt_r       <= CNT_W'(LATENCY);
                  beat_r      <= '0;
                  req_ready_r <= 1'b0;
                  state_r     <= (LATENCY == 0) ? BURST : WAIT;
               end
            end
            WAIT: begin
               req_ready_r <= 1'b0;
               cnt_r       <= cnt_r - CNT_W'(1);
               if (cnt_r <= CNT_W'(1)) begin
                  state_r <= BURST;
               end
            end
            BURST: begin
               req_ready_r <= 1'b0;
               if (last_take_s) begin
                  state_r      <= IDLE;
                  req_ready_r  <= 1'b1;
                  resp_valid_r <= 1'b0;
                  resp_last_r  <= 1'b0;
                  resp_err_r   <= 1'b0;
               end else if (load_s) begin
                  // Beat k is fetched as beat k-1 is accepted, so the output stays registered.
                  resp_valid_r <= 1'b1;
                  resp_last_r  <= (beat_r == BEAT_W'(WORDS_PER_LINE - 1));
                  resp_err_r   <= err_r;
                  beat_r       <= beat_r + BEAT_W'(1);
               end
            end
            default: begin
               state_r      <= IDLE;
               req_ready_r  <= 1'b0;
               resp_valid_r <= 1'b0;
               resp_last_r  <= 1'b0;
               resp_err_r   <= 1'b0;
            end
         endcase
      end
   end

   cache_refill_mem_array #(
      .MEM_WORDS (MEM_WORDS),
      .MEM_AW    (MEM_AW)
   ) u_array (
      .clk     (clk),
      .rst_n   (rst_n),
      .rd_en   (load_s),
      .rd_clr  (err_r),
      .rd_addr (rd_addr_s),
      .rd_data (rd_data_s)
`ifdef CACHE_REFILL_MEM_WRITE_EN
      ,
      .wr_en   (wr_en_s),
      .wr_addr (MEM_AW'(wr_idx_s)),
      .wr_data (bus.wr_data)
`endif
   );

   assign bus.req_ready  = req_ready_r && !wr_block_s;
   assign bus.resp_valid = resp_valid_r;
   assign bus.resp_data  = rd_data_s;
   assign bus.resp_last  = resp_last_r;
   assign bus.resp_err   = resp_err_r;
`ifdef CACHE_REFILL_MEM_WRITE_EN
   assign bus.wr_ready   = wr_ready_s;
`endif

endmodule

// File: tb/tb_cache_refill_mem.sv
// Self-checking bench for cache_refill_mem against a word-array reference model.
// Write-port scenarios are compiled only with CACHE_REFILL_MEM_WRITE_EN.
`timescale 1ns/1ps
module tb_cache_refill_mem;

   localparam int ADDR_W    = 32;
   localparam int MEM_WORDS = 1024;
   localparam int WPL       = 4;
   localparam int LAT       = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   cache_refill_mem_if #(.ADDR_W(ADDR_W)) bus();

   cache_refill_mem #(
      .ADDR_W         (ADDR_W),
      .MEM_WORDS      (MEM_WORDS),
      .WORDS_PER_LINE (WPL),
      .LATENCY        (LAT)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] ref_mem [MEM_WORDS];

   logic [31:0] cap_data [$];
   logic        cap_last [$];
   logic        cap_err  [$];
   logic [31:0] stall_data [$];
   logic        stall_last [$];
   int          cap_lat;
   bit          cap_timeout;
   logic        cap_rdy_acc;
   logic        post_valid;
   logic        post_ready;

   // Reference: line base from the word index, out of range if the line passes the end.
   function automatic bit model_oob(input logic [31:0] addr);
      longint base;
      base = (longint'(addr) / 4) / WPL * WPL;
      return (base + WPL) > MEM_WORDS;
   endfunction

   function automatic logic [31:0] model_data(input logic [31:0] addr, input int beat);
      longint base;
      base = (longint'(addr) / 4) / WPL * WPL;
      if ((base + WPL) > MEM_WORDS) return 32'h0;
      return ref_mem[int'(base) + beat];
   endfunction

   // Issues one request and records the burst; a stall or random backpressure can be applied.
   task automatic collect(input logic [31:0] addr, input int stall_beat, input int stall_n,
                          input bit rnd, input int abort_at);
      int guard;
      int beat;
      int stall_left;
      cap_data.delete(); cap_last.delete(); cap_err.delete();
      stall_data.delete(); stall_last.delete();
      cap_lat = -1; cap_timeout = 1'b0; stall_left = stall_n;
      post_valid = 1'bx; post_ready = 1'bx; cap_rdy_acc = 1'bx;
      @(negedge clk);
      bus.req_valid = 1'b1; bus.req_addr = addr; bus.resp_ready = 1'b0;
      guard = 0;
      while (bus.req_ready !== 1'b1 && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 50) begin
         cap_timeout = 1'b1; bus.req_valid = 1'b0;
         return;
      end
      @(negedge clk);
      bus.req_valid = 1'b0;
      cap_rdy_acc = bus.req_ready;
      guard = 0;
      while (bus.resp_valid !== 1'b1 && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      cap_lat = guard;
      if (guard >= 50) begin
         cap_timeout = 1'b1;
         return;
      end
      beat = 0; guard = 0;
      while (beat < abort_at && guard < 400) begin
         if (bus.resp_valid !== 1'b1) begin
            bus.resp_ready = 1'b0;
         end else if (beat == stall_beat && stall_left > 0) begin
            bus.resp_ready = 1'b0;
            stall_data.push_back(bus.resp_data);
            stall_last.push_back(bus.resp_last);
            stall_left--;
         end else if (rnd && $urandom_range(0, 2) == 0) begin
            bus.resp_ready = 1'b0;
         end else begin
            bus.resp_ready = 1'b1;
            cap_data.push_back(bus.resp_data);
            cap_last.push_back(bus.resp_last);
            cap_err.push_back(bus.resp_err);
            beat++;
         end
         @(negedge clk);
         guard++;
      end
      bus.resp_ready = 1'b0;
      if (beat < abort_at) cap_timeout = 1'b1;
      post_valid = bus.resp_valid;
      post_ready = bus.req_ready;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         n_checks++;
         if (bus.req_ready !== 1'b0) begin
            n_errors++; $display("FAIL reset_req_ready edge%0d: got %b want 0", i, bus.req_ready);
         end
         n_checks++;
         if (bus.resp_valid !== 1'b0) begin
            n_errors++; $display("FAIL reset_resp_valid edge%0d: got %b want 0", i, bus.resp_valid);
         end
      end
      n_checks++;
      if ({bus.resp_data, bus.resp_last, bus.resp_err} !== 34'h0) begin
         n_errors++; $display("FAIL reset_outputs: got data=%h last=%b err=%b want 0", bus.resp_data, bus.resp_last, bus.resp_err);
      end
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if (bus.req_ready !== 1'b1) begin
         n_errors++; $display("FAIL release_req_ready: got %b want 1", bus.req_ready);
      end
   endtask

   task automatic test_basic;
      collect(32'h8, -1, 0, 1'b0, WPL);
      n_checks++;
      if (cap_timeout !== 1'b0) begin n_errors++; $display("FAIL basic_timeout: got 1 want 0"); end
      n_checks++;
      if (cap_lat != LAT + 1) begin n_errors++; $display("FAIL basic_latency: got %0d want %0d", cap_lat, LAT + 1); end
      n_checks++;
      if (cap_rdy_acc !== 1'b0) begin n_errors++; $display("FAIL basic_busy_ready: got %b want 0", cap_rdy_acc); end
      for (int b = 0; b < cap_data.size(); b++) begin
         n_checks++;
         if (cap_data[b] !== 32'(b) || cap_last[b] !== (b == WPL - 1) || cap_err[b] !== 1'b0) begin
            n_errors++;
            $display("FAIL basic_beat%0d: got data=%h last=%b err=%b want data=%h last=%b err=0",
                     b, cap_data[b], cap_last[b], cap_err[b], 32'(b), (b == WPL - 1));
         end
      end
      n_checks++;
      if (post_valid !== 1'b0 || post_ready !== 1'b1) begin
         n_errors++; $display("FAIL basic_after: got valid=%b ready=%b want valid=0 ready=1", post_valid, post_ready);
      end
   endtask

   task automatic test_stall;
      collect(32'hC, 1, 3, 1'b0, WPL);
      n_checks++;
      if (cap_timeout !== 1'b0 || stall_data.size() != 3) begin
         n_errors++; $display("FAIL stall_run: got timeout=%b stalls=%0d want 0/3", cap_timeout, stall_data.size());
      end
      for (int i = 0; i < stall_data.size(); i++) begin
         n_checks++;
         if (stall_data[i] !== 32'h1 || stall_last[i] !== 1'b0) begin
            n_errors++; $display("FAIL stall_hold%0d: got data=%h last=%b want data=1 last=0", i, stall_data[i], stall_last[i]);
         end
      end
      for (int b = 0; b < cap_data.size(); b++) begin
         n_checks++;
         if (cap_data[b] !== model_data(32'hC, b) || cap_last[b] !== (b == WPL - 1)) begin
            n_errors++; $display("FAIL stall_beat%0d: got data=%h last=%b want data=%h", b, cap_data[b], cap_last[b], model_data(32'hC, b));
         end
      end
   endtask

   task automatic test_out_of_range;
      collect(32'h1000, -1, 0, 1'b0, WPL);
      n_checks++;
      if (cap_timeout !== 1'b0 || cap_data.size() != WPL) begin
         n_errors++; $display("FAIL oob_run: got timeout=%b beats=%0d want 0/%0d", cap_timeout, cap_data.size(), WPL);
      end
      for (int b = 0; b < cap_data.size(); b++) begin
         n_checks++;
         if (cap_data[b] !== 32'h0 || cap_err[b] !== 1'b1 || cap_last[b] !== (b == WPL - 1)) begin
            n_errors++; $display("FAIL oob_beat%0d: got data=%h err=%b last=%b want data=0 err=1", b, cap_data[b], cap_err[b], cap_last[b]);
         end
      end
   endtask

   task automatic test_reset_mid_burst;
      collect(32'h40, -1, 0, 1'b0, 3);
      rst_n = 1'b0;
      @(negedge clk);
      n_checks++;
      if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b0 || bus.resp_data !== 32'h0) begin
         n_errors++; $display("FAIL midrst_state: got valid=%b ready=%b data=%h want 0/0/0", bus.resp_valid, bus.req_ready, bus.resp_data);
      end
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
         n_errors++; $display("FAIL midrst_release: got valid=%b ready=%b want 0/1", bus.resp_valid, bus.req_ready);
      end
      collect(32'h20, -1, 0, 1'b0, WPL);
      n_checks++;
      if (cap_timeout !== 1'b0 || cap_lat != LAT + 1) begin
         n_errors++; $display("FAIL midrst_next: got timeout=%b lat=%0d want 0/%0d", cap_timeout, cap_lat, LAT + 1);
      end
      for (int b = 0; b < cap_data.size(); b++) begin
         n_checks++;
         if (cap_data[b] !== 32'(8 + b) || cap_err[b] !== 1'b0) begin
            n_errors++; $display("FAIL midrst_beat%0d: got data=%h err=%b want data=%h err=0", b, cap_data[b], cap_err[b], 32'(8 + b));
         end
      end
   endtask

   task automatic test_random;
      logic [31:0] addr;
      for (int it = 0; it < 24; it++) begin
         case ($urandom_range(0, 3))
            0:       addr = $urandom();
            1:       addr = 32'($urandom_range(0, 4095));
            2:       addr = 32'($urandom_range(4064, 4127));
            default: addr = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
         endcase
         collect(addr, -1, 0, 1'b1, WPL);
         n_checks++;
         if (cap_timeout !== 1'b0 || cap_lat != LAT + 1 || post_ready !== 1'b1) begin
            n_errors++; $display("FAIL rand%0d_run addr=%h: got timeout=%b lat=%0d ready=%b", it, addr, cap_timeout, cap_lat, post_ready);
         end
         for (int b = 0; b < cap_data.size(); b++) begin
            n_checks++;
            if (cap_data[b] !== model_data(addr, b) || cap_err[b] !== model_oob(addr) || cap_last[b] !== (b == WPL - 1)) begin
               n_errors++;
               $display("FAIL rand%0d_beat%0d addr=%h: got data=%h err=%b last=%b want data=%h err=%b",
                        it, b, addr, cap_data[b], cap_err[b], cap_last[b], model_data(addr, b), model_oob(addr));
            end
         end
      end
   endtask

`ifdef CACHE_REFILL_MEM_WRITE_EN
   task automatic test_write;
      @(negedge clk);
      bus.wr_valid = 1'b1; bus.wr_addr = 32'h14; bus.wr_data = 32'hDEAD_BEEF;
      bus.req_valid = 1'b1; bus.req_addr = 32'h10;
      #1;
      n_checks++;
      if (bus.req_ready !== 1'b0 || bus.wr_ready !== 1'b1) begin
         n_errors++; $display("FAIL wr_priority: got req_ready=%b wr_ready=%b want 0/1", bus.req_ready, bus.wr_ready);
      end
      @(negedge clk);
      ref_mem[5] = 32'hDEAD_BEEF;
      bus.wr_valid = 1'b0; bus.req_valid = 1'b0;
      #1;
      n_checks++;
      if (bus.req_ready !== 1'b1) begin
         n_errors++; $display("FAIL wr_no_accept: got req_ready=%b want 1", bus.req_ready);
      end
      // Dropped write: must not alias onto word 0.
      bus.wr_valid = 1'b1; bus.wr_addr = 32'h1000; bus.wr_data = 32'hBAD0_BAD0;
      @(negedge clk);
      bus.wr_valid = 1'b0;
      collect(32'h10, -1, 0, 1'b0, WPL);
      n_checks++;
      if (cap_data.size() != WPL || cap_data[1] !== 32'hDEAD_BEEF) begin
         n_errors++; $display("FAIL wr_readback: got beats=%0d want word1=deadbeef", cap_data.size());
      end
      for (int b = 0; b < cap_data.size(); b++) begin
         n_checks++;
         if (cap_data[b] !== model_data(32'h10, b)) begin
            n_errors++; $display("FAIL wr_beat%0d: got %h want %h", b, cap_data[b], model_data(32'h10, b));
         end
      end
      collect(32'h0, -1, 0, 1'b0, WPL);
      for (int b = 0; b < cap_data.size(); b++) begin
         n_checks++;
         if (cap_data[b] !== model_data(32'h0, b)) begin
            n_errors++; $display("FAIL wr_drop_beat%0d: got %h want %h", b, cap_data[b], model_data(32'h0, b));
         end
      end
   endtask
`endif

   initial begin
      for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = 32'(i);
      bus.req_valid = 1'b0; bus.req_addr = '0; bus.resp_ready = 1'b0;
`ifdef CACHE_REFILL_MEM_WRITE_EN
      bus.wr_valid = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
`endif
      test_reset();
      test_basic();
      test_stall();
      test_out_of_range();
      test_reset_mid_burst();
`ifdef CACHE_REFILL_MEM_WRITE_EN
      test_write();
`endif
      test_random();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
